// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared types and constants for the down_counter slice.
// Holds the FSM state encoding, the default width and the prescaler width helper.
package down_counter_pkg;

    localparam int DC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_EXP  = 2'b10
    } dc_state_e;

    // Prescaler count width; never below one bit so pre=1 still has a register.
    function automatic int pc_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/down_counter_prescaler.sv
// down_counter_prescaler: counts enabled pulses and flags every pre-th one.
// Ports: clk, rst_b (async low), clr (sync), en (pulse in), tick (comb out).
import down_counter_pkg::*;

module down_counter_prescaler #(
    parameter int pre = 1
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = pc_width(pre);
    localparam logic [PW-1:0] LAST = PW'(pre - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = en & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_counter.sv
// down_counter: loadable down-counter/timer with reload, prescaler and tc pulse.
// Ports: clk, rst_b, clr, ld, din, c_down, auto_rl in; q, zero, tc, busy out.
import down_counter_pkg::*;

module down_counter #(
    parameter int w   = DC_W,
    parameter int pre = 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         ld,
    input  logic [w-1:0] din,
    input  logic         c_down,
    input  logic         auto_rl,
    output logic [w-1:0] q,
    output logic         zero,
    output logic         tc,
    output logic         busy
);

    dc_state_e    state_q, state_d;
    logic [w-1:0] q_q, q_d;
    logic [w-1:0] rl_q, rl_d;
    logic         tc_q, tc_d;
    logic         busy_q, busy_d;
    logic         pre_en;
    logic         tick;

    // Pulses only advance the prescaler while running.
    assign pre_en = c_down & (state_q == ST_RUN);

    down_counter_prescaler #(
        .pre(pre)
    ) u_pre (
        .clk  (clk),
        .rst_b(rst_b),
        .clr  (clr | ld),
        .en   (pre_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        tc_d    = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            q_d     = '0;
        end else if (ld) begin
            q_d     = din;
            rl_d    = din;
            state_d = (din != '0) ? ST_RUN : ST_EXP;
        end else if (tick) begin
            if (q_q > w'(1)) begin
                q_d = q_q - w'(1);
            end else begin
                tc_d = 1'b1;
                if (auto_rl) begin
                    q_d = rl_q;
                end else begin
                    q_d     = '0;
                    state_d = ST_EXP;
                end
            end
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rl_q    <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
            tc_q    <= tc_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign zero = (q_q == '0);
    assign tc   = tc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed and random stimulus against a reference model.
// Two instances (pre=1, pre=4) share inputs and are checked every cycle.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       clr, ld, c_down, auto_rl;
    logic [7:0] din;
    logic [7:0] q1, q4;
    logic       zero1, tc1, busy1;
    logic       zero4, tc4, busy4;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: index 0 is pre=1, index 1 is pre=4.
    // m_mode: 0 idle, 1 running, 2 expired.
    int m_q[2], m_rl[2], m_pulses[2], m_mode[2], m_tc[2];
    int m_pre[2] = '{1, 4};

    always #5 clk = ~clk;

    down_counter #(.w(8), .pre(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .din(din),
        .c_down(c_down), .auto_rl(auto_rl),
        .q(q1), .zero(zero1), .tc(tc1), .busy(busy1)
    );

    down_counter #(.w(8), .pre(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .clr(clr), .ld(ld), .din(din),
        .c_down(c_down), .auto_rl(auto_rl),
        .q(q4), .zero(zero4), .tc(tc4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_rl[k] = 0; m_pulses[k] = 0;
            m_mode[k] = 0; m_tc[k] = 0;
        end
    endtask

    task automatic mstep();
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            if (clr) begin
                m_q[k] = 0; m_pulses[k] = 0; m_mode[k] = 0;
            end else if (ld) begin
                m_q[k] = din; m_rl[k] = din; m_pulses[k] = 0;
                m_mode[k] = (din != 0) ? 1 : 2;
            end else if (c_down && m_mode[k] == 1) begin
                m_pulses[k] = m_pulses[k] + 1;
                if (m_pulses[k] == m_pre[k]) begin
                    m_pulses[k] = 0;
                    if (m_q[k] > 1) begin
                        m_q[k] = m_q[k] - 1;
                    end else begin
                        m_tc[k] = 1;
                        if (auto_rl) m_q[k] = m_rl[k];
                        else begin m_q[k] = 0; m_mode[k] = 2; end
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("q_p1", q1, m_q[0]);
        chk("tc_p1", tc1, m_tc[0]);
        chk("busy_p1", busy1, m_mode[0] == 1);
        chk("zero_p1", zero1, m_q[0] == 0);
        chk("q_p4", q4, m_q[1]);
        chk("tc_p4", tc4, m_tc[1]);
        chk("busy_p4", busy4, m_mode[1] == 1);
        chk("zero_p4", zero4, m_q[1] == 0);
    endtask

    task automatic step(input logic c, input logic l, input logic [7:0] d,
                        input logic cd, input logic ar);
        clr = c; ld = l; din = d; c_down = cd; auto_rl = ar;
        @(posedge clk);
        mstep();
        #1;
        check_all();
    endtask

    initial begin
        rst_b = 1'b0;
        clr = 0; ld = 0; din = 0; c_down = 0; auto_rl = 0;
        mreset();
        #1;
        check_all();
        #20 rst_b = 1'b1;

        // Count 5 down to 0, then hold.
        step(0, 1, 8'd5, 1, 0);
        chk("t1_q_load", q1, 5);
        for (int i = 0; i < 5; i++) step(0, 0, 8'd0, 1, 0);
        chk("t1_tc", tc1, 1);
        chk("t1_busy", busy1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 1, 0);
        chk("t1_hold", q1, 0);

        // Auto-reload of 3.
        step(0, 1, 8'd3, 1, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 8'd0, 1, 1);
        chk("t2_q", q1, 3);
        chk("t2_tc", tc1, 1);
        chk("t2_busy", busy1, 1);

        // Prescale by 4, load 2: tc on the 8th pulse.
        step(0, 1, 8'd2, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 8'd0, 1, 0);
        chk("t3_tc_p4", tc4, 1);

        // Clear mid-count, then c_down is ignored.
        step(0, 1, 8'd6, 1, 0);
        step(0, 0, 8'd0, 1, 0);
        step(0, 0, 8'd0, 1, 0);
        step(1, 1, 8'd9, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 1, 0);
        chk("t4_q", q1, 0);

        // Load beats a terminal decrement; load of 0 expires.
        step(0, 1, 8'd2, 1, 0);
        step(0, 0, 8'd0, 1, 0);
        step(0, 1, 8'd7, 1, 0);
        chk("t5_q", q1, 7);
        chk("t5_tc", tc1, 0);
        step(0, 1, 8'd0, 1, 0);
        chk("t5_zero", zero1, 1);

        // Asynchronous reset mid-count.
        step(0, 1, 8'd6, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 1, 0);
        #2 rst_b = 1'b0;
        #1;
        mreset();
        chk("rst_q", q1, 0);
        chk("rst_tc", tc1, 0);
        check_all();
        #4 rst_b = 1'b1;
        step(0, 0, 8'd0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                            : 8'($urandom_range(0, 6));
            step($urandom_range(0, 31) == 0, $urandom_range(0, 9) == 0, d,
                 $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
